pc_sequencer: RTL and testbench

- Next-PC controller for the fetch stage of the 5-stage RISC-V pipeline. Owns the program-counter register and sequences it.
- Chooses between sequential, branch-redirect (EX), jump-redirect (ID), stall and halt. Generates pipeline flushes.
- Sequences boot after reset. Keeps saturating stall and redirect performance counters.

---
 rtl/pc_pkg.sv | 8 +
 rtl/pc_sequencer_sat_counter.sv | 16 +
 rtl/pc_sequencer.sv | 95 +++++++++
 tb/tb_pc_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage next-PC sequencer.
package pc_pkg;
   localparam int          XLEN         = 32;
   localparam int          INSN_BYTES   = 4;
   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

   typedef enum logic [1:0] {BOOT, RUN, HALT} pc_state_e;
endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear, used for perf statistics.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                    count <= '0;
      else if (clr)                  count <= '0;
      else if (inc && (count != '1)) count <= count + W'(1);
   end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC owner: boot delay, branch/jump redirect, stall hold, halt,
// pipeline flush generation and saturating stall/redirect counters.
module pc_sequencer import pc_pkg::*; #(
   parameter int              XLEN         = pc_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(pc_pkg::RESET_VECTOR),
   parameter int              BOOT_DELAY   = 2,
   parameter int              CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_i,
   input  logic             imem_ready,
   input  logic             br_taken,
   input  logic [XLEN-1:0]  br_target,
   input  logic             jump,
   input  logic [XLEN-1:0]  jump_target,
   input  logic             halt_i,
   output logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  pc_plus4,
   output logic             fetch_valid,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             misalign_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] redirect_cnt
);
   localparam int BW      = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
   localparam int BD_LAST = (BOOT_DELAY > 0) ? BOOT_DELAY - 1 : 0;

   pc_state_e       state;
   logic [BW-1:0]   boot_cnt;
   logic            run;
   logic            redirect;
   logic            hold;
   logic [XLEN-1:0] tgt;
   logic            stall_inc;
   logic            redir_inc;

   assign run      = (state == RUN);
   assign redirect = br_taken | jump;
   // Branch wins: the jumping instruction in ID is younger than the branch in EX.
   assign tgt      = br_taken ? br_target : jump_target;
   assign hold     = stall_i | ~imem_ready;

   assign pc_plus4    = pc + XLEN'(INSN_BYTES);
   assign fetch_valid = run;
   assign flush_if_id = run & redirect;
   assign flush_id_ex = run & br_taken;
   assign stall_inc   = run & ~redirect & hold;
   assign redir_inc   = run & redirect;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= BOOT;
         boot_cnt     <= '0;
         pc           <= RESET_VECTOR;
         misalign_err <= 1'b0;
      end else begin
         case (state)
            BOOT: begin
               if ((BOOT_DELAY == 0) || (boot_cnt == BW'(BD_LAST))) state <= RUN;
               else boot_cnt <= boot_cnt + BW'(1);
            end
            RUN: begin
               // Redirects are taken immediately and override any stall.
               if (redirect) begin
                  pc <= {tgt[XLEN-1:2], 2'b00};
                  if (tgt[1:0] != 2'b00) misalign_err <= 1'b1;
               end else if (!hold) begin
                  pc <= pc_plus4;
               end
               if (halt_i) state <= HALT;
            end
            HALT: ;
            default: state <= BOOT;
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_inc),
      .clr   (1'b0),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_redirect_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (redir_inc),
      .clr   (1'b0),
      .count (redirect_cnt)
   );
endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised and directed bench for pc_sequencer against a behavioural PC model.
module tb_pc_sequencer;
   localparam int BOOT_DELAY = 2;
   localparam int CNT_W      = 16;
   localparam int CMAX       = (1 << CNT_W) - 1;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall_i = 1'b0, imem_ready = 1'b1, br_taken = 1'b0, jump = 1'b0, halt_i = 1'b0;
   logic [31:0] br_target = '0, jump_target = '0;
   logic [31:0] pc, pc_plus4;
   logic        fetch_valid, flush_if_id, flush_id_ex, misalign_err;
   logic [15:0] stall_cnt, redirect_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model: phase 0=boot 1=run 2=halt
   logic [31:0] m_pc;
   int          m_ph, m_boot, m_stall, m_redir;
   logic        m_mis;

   pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .BOOT_DELAY(BOOT_DELAY), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .stall_i(stall_i), .imem_ready(imem_ready),
      .br_taken(br_taken), .br_target(br_target), .jump(jump), .jump_target(jump_target),
      .halt_i(halt_i), .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
      .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .misalign_err(misalign_err),
      .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_pc = 32'h0; m_ph = 0; m_boot = 0; m_stall = 0; m_redir = 0; m_mis = 1'b0;
   endtask

   task automatic clear_inputs();
      stall_i = 0; imem_ready = 1; br_taken = 0; jump = 0; halt_i = 0;
      br_target = '0; jump_target = '0;
   endtask

   // advance the model with the current inputs, then clock the DUT
   task automatic tick();
      logic [31:0] t;
      if (m_ph == 0) begin
         m_boot++;
         if (m_boot >= BOOT_DELAY) m_ph = 1;
      end else if (m_ph == 1) begin
         if (br_taken || jump) begin
            t = br_taken ? br_target : jump_target;
            if (t % 4 != 0) m_mis = 1'b1;
            m_pc = t - (t % 4);
            if (m_redir < CMAX) m_redir++;
         end else if (stall_i || !imem_ready) begin
            if (m_stall < CMAX) m_stall++;
         end else begin
            m_pc = m_pc + 32'd4;
         end
         if (halt_i) m_ph = 2;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 0; br_taken = 1; jump = 1; br_target = 32'h44; jump_target = 32'h88;
      #12;
      model_reset();
      n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
      n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv: got %b want 0", fetch_valid); end
      n_checks++; if ({flush_if_id, flush_id_ex} !== 2'b00) begin n_fail++; $display("FAIL reset_flush: got %b want 00", {flush_if_id, flush_id_ex}); end
      n_checks++; if ({misalign_err, stall_cnt, redirect_cnt} !== 33'h0) begin n_fail++; $display("FAIL reset_cnt: got %b/%h/%h want 0", misalign_err, stall_cnt, redirect_cnt); end
      clear_inputs();
      @(posedge clk); #1;
      reset = 1;
   endtask

   task automatic test_boot();
      logic [31:0] exp_pc [6] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
      logic        exp_fv [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 6; i++) begin
         if (i > 0) tick();
         n_checks++; if (pc !== exp_pc[i] || pc !== m_pc) begin n_fail++; $display("FAIL boot_pc[%0d]: got %h want %h", i, pc, exp_pc[i]); end
         n_checks++; if (fetch_valid !== exp_fv[i]) begin n_fail++; $display("FAIL boot_fv[%0d]: got %b want %b", i, fetch_valid, exp_fv[i]); end
      end
   endtask

   task automatic test_branch_over_stall();
      logic [15:0] sc;
      tick();
      n_checks++; if (pc !== 32'h10) begin n_fail++; $display("FAIL bos_start: got %h want 10", pc); end
      sc = stall_cnt;
      stall_i = 1; br_taken = 1; br_target = 32'h40; jump = 1; jump_target = 32'h80;
      #1;
      n_checks++; if ({flush_if_id, flush_id_ex} !== 2'b11) begin n_fail++; $display("FAIL bos_flush: got %b want 11", {flush_if_id, flush_id_ex}); end
      tick();
      clear_inputs();
      n_checks++; if (pc !== 32'h40) begin n_fail++; $display("FAIL bos_pc: got %h want 40", pc); end
      n_checks++; if (redirect_cnt !== 16'd1) begin n_fail++; $display("FAIL bos_redir: got %0d want 1", redirect_cnt); end
      n_checks++; if (stall_cnt !== sc) begin n_fail++; $display("FAIL bos_stall: got %0d want %0d", stall_cnt, sc); end
   endtask

   task automatic test_stall_hold();
      jump = 1; jump_target = 32'h20;
      tick();
      jump = 0; imem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (pc !== 32'h20) begin n_fail++; $display("FAIL hold_pc[%0d]: got %h want 20", i, pc); end
      end
      imem_ready = 1;
      tick();
      n_checks++; if (pc !== 32'h24) begin n_fail++; $display("FAIL hold_next: got %h want 24", pc); end
      n_checks++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL hold_cnt: got %0d want 3", stall_cnt); end
   endtask

   task automatic test_misaligned_jump();
      jump = 1; jump_target = 32'h103;
      #1;
      n_checks++; if ({flush_if_id, flush_id_ex} !== 2'b10) begin n_fail++; $display("FAIL mis_flush: got %b want 10", {flush_if_id, flush_id_ex}); end
      tick();
      clear_inputs();
      n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL mis_pc: got %h want 100", pc); end
      n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_set: got %b want 1", misalign_err); end
      for (int i = 0; i < 10; i++) tick();
      n_checks++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL mis_sticky: got %b want 1", misalign_err); end
      n_checks++; if (pc !== m_pc) begin n_fail++; $display("FAIL mis_run: got %h want %h", pc, m_pc); end
   endtask

   task automatic test_wrap();
      jump = 1; jump_target = 32'hFFFF_FFFC;
      tick();
      jump = 0;
      n_checks++; if (pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_plus4: got %h want 0", pc_plus4); end
      tick();
      n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h want 0", pc); end
   endtask

   task automatic test_random();
      int bad = 0;
      for (int i = 0; i < 400; i++) begin
         br_taken    = ($urandom_range(0, 7) == 0);
         jump        = ($urandom_range(0, 6) == 0);
         stall_i     = ($urandom_range(0, 3) == 0);
         imem_ready  = ($urandom_range(0, 4) != 0);
         br_target   = $urandom;
         jump_target = $urandom;
         #1;
         n_checks++;
         if (flush_if_id !== (br_taken | jump) || flush_id_ex !== br_taken) begin
            n_fail++; $display("FAIL rnd_flush[%0d]: got %b%b want %b%b", i, flush_if_id, flush_id_ex, br_taken | jump, br_taken);
         end
         tick();
         n_checks++;
         if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || fetch_valid !== 1'b1 || misalign_err !== m_mis ||
             stall_cnt !== 16'(m_stall) || redirect_cnt !== 16'(m_redir)) begin
            n_fail++;
            if (bad++ < 5)
               $display("FAIL rnd_state[%0d]: got pc=%h mis=%b sc=%0d rc=%0d want pc=%h mis=%b sc=%0d rc=%0d",
                        i, pc, misalign_err, stall_cnt, redirect_cnt, m_pc, m_mis, m_stall, m_redir);
         end
      end
      clear_inputs();
   endtask

   task automatic test_saturation();
      logic [31:0] p;
      p = m_pc;
      stall_i = 1;
      for (int i = 0; i < (1 << CNT_W) + 5; i++) tick();
      stall_i = 0;
      n_checks++; if (stall_cnt !== 16'hFFFF || m_stall != CMAX) begin n_fail++; $display("FAIL sat_cnt: got %h want ffff", stall_cnt); end
      n_checks++; if (pc !== p) begin n_fail++; $display("FAIL sat_pc: got %h want %h", pc, p); end
      n_checks++; if (redirect_cnt !== 16'(m_redir)) begin n_fail++; $display("FAIL sat_redir: got %0d want %0d", redirect_cnt, m_redir); end
   endtask

   task automatic test_halt_reset();
      halt_i = 1; br_taken = 1; br_target = 32'h200;
      tick();
      clear_inputs();
      n_checks++; if (pc !== 32'h200) begin n_fail++; $display("FAIL halt_pc: got %h want 200", pc); end
      n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL halt_fv: got %b want 0", fetch_valid); end
      for (int i = 0; i < 5; i++) begin
         br_taken = 1; br_target = $urandom; jump = 1; jump_target = $urandom;
         #1;
         n_checks++; if ({flush_if_id, flush_id_ex} !== 2'b00) begin n_fail++; $display("FAIL halt_flush[%0d]: got %b want 00", i, {flush_if_id, flush_id_ex}); end
         tick();
         n_checks++; if (pc !== 32'h200 || m_pc !== 32'h200) begin n_fail++; $display("FAIL halt_frozen[%0d]: got %h want 200", i, pc); end
      end
      clear_inputs();
      @(posedge clk); #3;
      reset = 0;
      #1;
      model_reset();
      n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL async_pc: got %h want 0", pc); end
      n_checks++; if ({fetch_valid, misalign_err, stall_cnt, redirect_cnt} !== 34'h0) begin
         n_fail++; $display("FAIL async_clr: got fv=%b mis=%b sc=%h rc=%h want 0", fetch_valid, misalign_err, stall_cnt, redirect_cnt);
      end
      @(posedge clk); #1;
      reset = 1;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (fetch_valid !== (i >= BOOT_DELAY)) begin n_fail++; $display("FAIL reboot_fv[%0d]: got %b want %b", i, fetch_valid, i >= BOOT_DELAY); end
         tick();
      end
      n_checks++; if (pc !== m_pc || pc !== 32'h4) begin n_fail++; $display("FAIL reboot_pc: got %h want 4", pc); end
   endtask

   initial begin
      test_reset();
      test_boot();
      test_branch_over_stall();
      test_stall_hold();
      test_misaligned_jump();
      test_wrap();
      test_random();
      test_saturation();
      test_halt_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
